// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage load/store sequencer for a multi-cycle req/ack data memory
module mem_access_ctrl #(
    parameter int          TIMEOUT  = 15,
    parameter logic [31:0] ERR_DATA = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        MEM_MemRd,
    input  logic        MEM_MemWr,
    input  logic [31:0] MEM_Addr,
    input  logic [31:0] MEM_WrData,
    output logic        Mem_Req,
    output logic        Mem_We,
    output logic [31:0] Mem_Addr,
    output logic [31:0] Mem_Wdata,
    input  logic [31:0] Mem_Rdata,
    input  logic        Mem_Ack,
    output logic        Stall,
    output logic [31:0] MEM_Dout,
    output logic        AddrErr,
    output logic        Timeout
);
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
    state_t     state;
    logic [7:0] cnt;
    logic       acc;
    logic       mis;
    assign acc   = MEM_MemRd | MEM_MemWr;
    assign mis   = acc & (MEM_Addr[1:0] != 2'b00);
    assign Stall = ((state == IDLE) & acc & ~mis) | (state == REQ);
    // access FSM with registered memory interface, load data and error pulses
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= IDLE;
            cnt       <= 8'd0;
            Mem_Req   <= 1'b0;
            Mem_We    <= 1'b0;
            Mem_Addr  <= 32'd0;
            Mem_Wdata <= 32'd0;
            MEM_Dout  <= 32'd0;
            AddrErr   <= 1'b0;
            Timeout   <= 1'b0;
        end else begin
            AddrErr <= 1'b0;
            Timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (mis) begin
                        AddrErr <= 1'b1;
                    end else if (acc) begin
                        state     <= REQ;
                        Mem_Req   <= 1'b1;
                        Mem_We    <= MEM_MemWr;
                        Mem_Addr  <= {2'b00, MEM_Addr[31:2]};
                        Mem_Wdata <= MEM_WrData;
                        cnt       <= 8'd0;
                    end
                end
                REQ: begin
                    if (Mem_Ack) begin
                        state   <= DONE;
                        Mem_Req <= 1'b0;
                        if (!Mem_We) MEM_Dout <= Mem_Rdata;
                    end else if (cnt == 8'(TIMEOUT - 1)) begin
                        state   <= DONE;
                        Mem_Req <= 1'b0;
                        Timeout <= 1'b1;
                        if (!Mem_We) MEM_Dout <= ERR_DATA;
                    end else begin
                        cnt <= (cnt == 8'hFF) ? cnt : cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: transaction-level checks of mem_access_ctrl against a latency/result model
module tb_mem_access_ctrl;
    localparam int          TO  = 15;
    localparam logic [31:0] ERR = 32'h0000_0000;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        MEM_MemRd = 1'b0;
    logic        MEM_MemWr = 1'b0;
    logic [31:0] MEM_Addr = 32'd0;
    logic [31:0] MEM_WrData = 32'd0;
    logic        Mem_Req;
    logic        Mem_We;
    logic [31:0] Mem_Addr;
    logic [31:0] Mem_Wdata;
    logic [31:0] Mem_Rdata = 32'd0;
    logic        Mem_Ack = 1'b0;
    logic        Stall;
    logic [31:0] MEM_Dout;
    logic        AddrErr;
    logic        Timeout;

    int checks = 0;
    int errors = 0;

    mem_access_ctrl #(.TIMEOUT(TO), .ERR_DATA(ERR)) dut (
        .Clk(Clk), .Reset(Reset), .MEM_MemRd(MEM_MemRd), .MEM_MemWr(MEM_MemWr),
        .MEM_Addr(MEM_Addr), .MEM_WrData(MEM_WrData), .Mem_Req(Mem_Req), .Mem_We(Mem_We),
        .Mem_Addr(Mem_Addr), .Mem_Wdata(Mem_Wdata), .Mem_Rdata(Mem_Rdata), .Mem_Ack(Mem_Ack),
        .Stall(Stall), .MEM_Dout(MEM_Dout), .AddrErr(AddrErr), .Timeout(Timeout)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          dly;
        logic [31:0] rdata;
        int          stall;
        int          req;
        int          aerr;
        int          to;
        logic [31:0] dout;
    } vec_t;

    typedef struct {
        int          stall_n;
        int          req_n;
        int          aerr_n;
        int          to_n;
        logic [31:0] dout;
        logic        we;
        logic [31:0] maddr;
        logic [31:0] mwdata;
        logic        stable;
        logic        done;
    } obs_t;

    typedef struct {
        int          stall;
        int          req;
        int          aerr;
        int          to;
        logic [31:0] dout;
    } exp_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Outcome of one access from its timing rules: one IDLE stall cycle, then REQ cycles
    // until ack (dly+1) or until the timeout budget runs out.
    function automatic exp_t model(input logic rd, input logic wr, input logic [31:0] addr,
                                   input int dly, input logic [31:0] rdata, input logic [31:0] prev);
        exp_t e;
        int   n;
        e = '{0, 0, 0, 0, prev};
        if (!(rd | wr)) return e;
        if (addr % 4 != 0) begin
            e.aerr = 1;
            return e;
        end
        n       = (dly < TO) ? dly + 1 : TO;
        e.req   = n;
        e.stall = n + 1;
        e.to    = (dly >= TO) ? 1 : 0;
        e.dout  = wr ? prev : (e.to == 1 ? ERR : rdata);
        return e;
    endfunction

    // Presents one instruction to the MEM stage, holds it while stalled, acks after dly REQ cycles.
    task automatic run_access(input logic rd, input logic wr, input logic [31:0] addr,
                              input logic [31:0] wdata, input int dly, input logic [31:0] rdata,
                              output obs_t o);
        int reqcnt = 0;
        bit fin = 0;
        o = '{0, 0, 0, 0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0};
        MEM_MemRd  = rd;
        MEM_MemWr  = wr;
        MEM_Addr   = addr;
        MEM_WrData = wdata;
        Mem_Ack    = 1'b0;
        for (int c = 0; c < 40 && !o.done; c++) begin
            @(negedge Clk);
            if (Stall) o.stall_n++;
            if (AddrErr) o.aerr_n++;
            if (Timeout) o.to_n++;
            if (Mem_Req) begin
                if (reqcnt == 0) begin
                    o.we     = Mem_We;
                    o.maddr  = Mem_Addr;
                    o.mwdata = Mem_Wdata;
                end else if (Mem_We !== o.we || Mem_Addr !== o.maddr || Mem_Wdata !== o.mwdata) begin
                    o.stable = 1'b0;
                end
                reqcnt++;
                o.req_n++;
            end
            if (fin) o.done = 1'b1;
            else if (!Stall) begin
                fin    = 1;
                o.dout = MEM_Dout;
            end
            @(posedge Clk);
            #1;
            if (fin) begin
                MEM_MemRd = 1'b0;
                MEM_MemWr = 1'b0;
            end
            Mem_Ack   = Mem_Req && reqcnt == dly;
            Mem_Rdata = Mem_Ack ? rdata : $urandom;
        end
        Mem_Ack = 1'b0;
    endtask

    task automatic check_access(input string tag, input logic rd, input logic wr,
                                input logic [31:0] addr, input logic [31:0] wdata, input obs_t o,
                                input int stall, input int req, input int aerr, input int to,
                                input logic [31:0] dout);
        chk({tag, " done"}, 32'(o.done), 32'd1);
        chk({tag, " stall_cycles"}, 32'(o.stall_n), 32'(stall));
        chk({tag, " req_cycles"}, 32'(o.req_n), 32'(req));
        chk({tag, " addr_err"}, 32'(o.aerr_n), 32'(aerr));
        chk({tag, " timeout"}, 32'(o.to_n), 32'(to));
        chk({tag, " dout"}, o.dout, dout);
        if (req > 0) begin
            chk({tag, " mem_we"}, 32'(o.we), 32'(wr));
            chk({tag, " mem_addr"}, o.maddr, addr >> 2);
            chk({tag, " mem_wdata"}, o.mwdata, wdata);
            chk({tag, " req_stable"}, 32'(o.stable), 32'd1);
        end
        if (!rd) chk({tag, " rd_unused"}, 32'(rd), 32'd0);
    endtask

    vec_t        tbl[8];
    obs_t        o;
    exp_t        e;
    logic [31:0] dmodel;
    logic [31:0] a;
    logic [1:0]  r;
    int          d;
    logic        req_pat[6]   = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic        stall_pat[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    initial begin
        tbl[0] = '{1'b1, 1'b0, 32'h0000_0040, 32'h0,         1,  32'h1234_5678, 3,  2,  0, 0, 32'h1234_5678};
        tbl[1] = '{1'b0, 1'b1, 32'h0000_0080, 32'hCAFE_F00D, 0,  32'h0,         2,  1,  0, 0, 32'h1234_5678};
        tbl[2] = '{1'b1, 1'b0, 32'h0000_0042, 32'h0,         0,  32'h0,         0,  0,  1, 0, 32'h1234_5678};
        tbl[3] = '{1'b1, 1'b0, 32'h0000_0100, 32'h0,         99, 32'h0,         16, 15, 0, 1, 32'h0000_0000};
        tbl[4] = '{1'b1, 1'b0, 32'h0000_0004, 32'h0,         14, 32'hA5A5_A5A5, 16, 15, 0, 0, 32'hA5A5_A5A5};
        tbl[5] = '{1'b1, 1'b1, 32'h0000_0008, 32'h1122_3344, 3,  32'h5555_0000, 5,  4,  0, 0, 32'hA5A5_A5A5};
        tbl[6] = '{1'b0, 1'b1, 32'h0000_0083, 32'h0,         0,  32'h0,         0,  0,  1, 0, 32'hA5A5_A5A5};
        tbl[7] = '{1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0,         0,  32'hDEAD_BEEF, 2,  1,  0, 0, 32'hDEAD_BEEF};

        repeat (2) @(posedge Clk);
        #1;
        Reset = 1'b0;
        @(negedge Clk);
        chk("rst mem_req", 32'(Mem_Req), 32'd0);
        chk("rst mem_we", 32'(Mem_We), 32'd0);
        chk("rst mem_addr", Mem_Addr, 32'd0);
        chk("rst mem_wdata", Mem_Wdata, 32'd0);
        chk("rst dout", MEM_Dout, 32'd0);
        chk("rst addr_err", 32'(AddrErr), 32'd0);
        chk("rst timeout", 32'(Timeout), 32'd0);
        chk("rst stall", 32'(Stall), 32'd0);
        @(posedge Clk);
        #1;

        for (int i = 0; i < 8; i++) begin
            run_access(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].dly, tbl[i].rdata, o);
            check_access($sformatf("vec%0d", i), tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata, o,
                         tbl[i].stall, tbl[i].req, tbl[i].aerr, tbl[i].to, tbl[i].dout);
        end

        dmodel = 32'hDEAD_BEEF;
        for (int i = 0; i < 60; i++) begin
            r = 2'($urandom_range(1, 3));
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            d = $urandom_range(0, TO + 1);
            tbl[0].wdata = $urandom;
            tbl[0].rdata = $urandom;
            e = model(r[0], r[1], a, d, tbl[0].rdata, dmodel);
            run_access(r[0], r[1], a, tbl[0].wdata, d, tbl[0].rdata, o);
            check_access($sformatf("rnd%0d", i), r[0], r[1], a, tbl[0].wdata, o,
                         e.stall, e.req, e.aerr, e.to, e.dout);
            dmodel = e.dout;
        end

        // reset two cycles into REQ, then a late ack must be ignored
        MEM_MemRd = 1'b1;
        MEM_Addr  = 32'h40;
        repeat (3) @(posedge Clk);
        #1;
        Reset     = 1'b1;
        MEM_MemRd = 1'b0;
        @(posedge Clk);
        #1;
        Reset     = 1'b0;
        Mem_Ack   = 1'b1;
        Mem_Rdata = 32'h9999_9999;
        @(negedge Clk);
        chk("rstmid mem_req", 32'(Mem_Req), 32'd0);
        chk("rstmid stall", 32'(Stall), 32'd0);
        chk("rstmid dout", MEM_Dout, 32'd0);
        @(posedge Clk);
        #1;
        Mem_Ack = 1'b0;
        @(negedge Clk);
        chk("rstmid late_ack dout", MEM_Dout, 32'd0);
        chk("rstmid late_ack req", 32'(Mem_Req), 32'd0);
        chk("rstmid late_ack timeout", 32'(Timeout), 32'd0);

        // ack while idle is ignored
        @(posedge Clk);
        #1;
        Mem_Ack   = 1'b1;
        Mem_Rdata = 32'h7777_7777;
        @(posedge Clk);
        #1;
        Mem_Ack = 1'b0;
        @(negedge Clk);
        chk("idle_ack dout", MEM_Dout, 32'd0);
        chk("idle_ack req", 32'(Mem_Req), 32'd0);

        // back-to-back loads with immediate acks, no bubble between them
        @(posedge Clk);
        #1;
        MEM_MemRd = 1'b1;
        MEM_Addr  = 32'h10;
        for (int c = 0; c < 6; c++) begin
            if (c == 3) MEM_Addr = 32'h14;
            Mem_Ack   = Mem_Req;
            Mem_Rdata = (Mem_Addr == 32'h4) ? 32'h1111_0010 : 32'h2222_0014;
            @(negedge Clk);
            chk($sformatf("b2b req c%0d", c), 32'(Mem_Req), 32'(req_pat[c]));
            chk($sformatf("b2b stall c%0d", c), 32'(Stall), 32'(stall_pat[c]));
            if (c == 4) chk("b2b second addr", Mem_Addr, 32'h5);
            if (c == 2) chk("b2b dout first", MEM_Dout, 32'h1111_0010);
            if (c == 5) chk("b2b dout second", MEM_Dout, 32'h2222_0014);
            @(posedge Clk);
            #1;
            if (c == 5) MEM_MemRd = 1'b0;
        end
        Mem_Ack = 1'b0;
        @(negedge Clk);
        chk("b2b idle req", 32'(Mem_Req), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
